mult_job_issuer: RTL

//   Initiator side of the multiplier controller start/state handshake. Buffers operand pairs,

---
 rtl/multiplier_states_pkg.sv | 22 ++
 rtl/mult_op_fifo.sv | 65 ++++++
 rtl/mult_job_issuer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/multiplier_states_pkg.sv
// Shared state encodings for the multiplier controller handshake.
// multiplier_states_t is the controller's 3-bit state code.
// Codes 6 and 7 are unused and are treated as neither IDLE nor END.
// issuer_state_t is the issuer's internal FSM encoding.
package multiplier_states_pkg;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_COMPUTE_PROD0 = 3'd1,
    ST_COMPUTE_PROD1 = 3'd2,
    ST_COMPUTE_PROD2 = 3'd3,
    ST_COMPUTE_PROD3 = 3'd4,
    ST_END           = 3'd5
  } multiplier_states_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DROP  = 2'd2
  } issuer_state_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Synchronous operand FIFO, DEPTH entries of DW bits (DEPTH must be a power of two).
// The read data always shows the head entry, so a pop takes that entry in the same cycle.
// A push while full and a pop while empty are both ignored.
module mult_op_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wr_data_i,
  output logic [DW-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Advance the pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage. No reset is needed because the count guards every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/mult_job_issuer.sv
// Initiator side of the multiplier start/state handshake.
// It buffers operand pairs and launches one job at a time by raising ctrl_strt_o.
// It captures the product when the controller reports ST_END and holds it on a valid/ready port.
// It then drops start and waits for the controller to return to ST_IDLE.
// Optional build macro: MULT_WATCHDOG_EN. It aborts a job that stays in S_START for TIMEOUT_CYC
// cycles without reaching ST_END, and sets the sticky err_timeout_o flag.
module mult_job_issuer #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               op_valid_i,
  output logic               op_ready_o,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  output logic               ctrl_strt_o,
  input  logic [2:0]         ctrl_state_i,
  output logic [WIDTH-1:0]   mult_a_o,
  output logic [WIDTH-1:0]   mult_b_o,
  input  logic [2*WIDTH-1:0] mult_prod_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [2*WIDTH-1:0] res_data_o,
  output logic               err_timeout_o
);

  import multiplier_states_pkg::*;

  issuer_state_t      state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               res_valid_q, res_valid_d;
  logic [2*WIDTH-1:0] res_data_q, res_data_d;
  logic               strt_q, strt_d;
  logic               fifo_full, fifo_empty;
  logic [2*WIDTH-1:0] fifo_rd;
  logic               launch, abort, wd_expired;

  mult_op_fifo #(.DW(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (op_valid_i),
    .pop_i     (launch),
    .wr_data_i ({op_a_i, op_b_i}),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // A launch needs the result slot to be free. The slot is free when it is empty now,
  // or when it is being drained on this same edge.
  assign launch = (state_q == S_IDLE) && !fifo_empty && (ctrl_state_i == ST_IDLE)
                  && (!res_valid_q || res_ready_i);

  // Next-state and datapath capture logic for the issuer FSM.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    abort       = 1'b0;
    if (res_valid_q && res_ready_i) res_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          a_d     = fifo_rd[2*WIDTH-1:WIDTH];
          b_d     = fifo_rd[WIDTH-1:0];
          state_d = S_START;
        end
      end
      S_START: begin
        if (ctrl_state_i == ST_END) begin
          res_data_d  = mult_prod_i;
          res_valid_d = 1'b1;
          state_d     = S_DROP;
        end else if (wd_expired) begin
          abort   = 1'b1;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (ctrl_state_i == ST_IDLE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    strt_d = (state_d == S_START);
  end

  // FSM, operand, result and start-request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      strt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      strt_q      <= strt_d;
    end
  end

`ifdef MULT_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          err_q, err_d;

  // Expiry fires on the TIMEOUT_CYC-th cycle spent in S_START.
  assign wd_expired = (state_q == S_START) && (wd_cnt_q == CW'(TIMEOUT_CYC - 1));

  // The cycle counter clears on launch and counts while in S_START. The error flag is sticky.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    err_d    = err_q | abort;
    if (launch) wd_cnt_d = '0;
    else if ((state_q == S_START) && !wd_expired) wd_cnt_d = wd_cnt_q + CW'(1);
  end

  // Watchdog registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_timeout_o = err_q;
`else
  assign wd_expired    = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  assign op_ready_o  = !fifo_full;
  assign ctrl_strt_o = strt_q;
  assign mult_a_o    = a_q;
  assign mult_b_o    = b_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;

endmodule
